seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Parametrised multiplexed seven-segment scanner. Successor to the fixed 4-digit display driver.
- Drives NUM_DIGITS common-anode/cathode digits from a packed hex bus. Adds:
  - a snapshot load strobe
  - per-digit blanking
  - per-digit blinking
  - an anti-ghosting dead time between digits
  - selectable output polarity
- Sits between the DDS/measurement datapath and the board display pins.

Parameters:
- NUM_DIGITS, 8: digits scanned; range 2..16.
- SCAN_DIV, 100000: clk cycles per digit slot; must be >= 2.
- BLANK_CYC, 1000: cycles at the start of each slot with all anodes off; must be < SCAN_DIV.
- BLINK_FRAMES, 64: full scan frames per blink half-period; must be >= 1.
- AN_ACTIVE_LOW, 0: 1 = anode-enable pins active-low.
- SEG_ACTIVE_LOW, 0: 1 = segment/dp pins active-low.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load  in  1  1-cycle strobe; captures hex_in/dp_in/blank_in/blink_in into shadow registers
- hex_in  in  4*NUM_DIGITS  digit i value at [4i+3:4i]
- dp_in  in  NUM_DIGITS  decimal point per digit
- blank_in  in  NUM_DIGITS  1 = digit i dark
- blink_in  in  NUM_DIGITS  1 = digit i blinks
- an  out  NUM_DIGITS  digit enables, one-hot when active
- sseg  out  8  {dp, a, b, c, d, e, f, g}; bit7 = dp, bit6 = a
- frame_tick  out  1  1-cycle pulse at end of each full scan frame

Behaviour:
- Reset (rst high at a clk edge):
  - slot counter, digit index, frame counter and blink phase all go to 0.
  - Shadow registers clear to 0.
  - an = all inactive; sseg = all inactive; frame_tick = 0.
  - Reset mid-scan aborts the current slot immediately.
- Shadow load:
  - On a load=1 edge, the shadows take the inputs.
  - Displayed data uses the shadows from the next cycle. Inputs are otherwise ignored.
  - Load coincident with a slot boundary still takes effect on the following cycle.
- Slot counter:
  - Counts 0..SCAN_DIV-1, then wraps.
  - On wrap, the digit index increments 0..NUM_DIGITS-1 and wraps to 0.
- frame_tick:
  - Asserted for one cycle, registered, in the cycle after the digit index wraps from NUM_DIGITS-1 to 0.
- Blink counter:
  - Counts frames 0..BLINK_FRAMES-1. On its wrap the blink phase toggles.
  - Phase 0 = visible, phase 1 = dark for blinking digits.
- Digit enable: digit k = current index is enabled iff all of the following hold:
  - slot count >= BLANK_CYC
  - shadow blank[k] = 0
  - !(shadow blink[k] & phase)
  - When enabled, an[k] is active and all other bits are inactive. Otherwise all an bits are inactive.
- Segments:
  - sseg[6:0] = decode(shadow hex[k]), abcdefg active-high before polarity.
  - Decode table:
    - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001
    - 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000
    - 8 = 1111111, 9 = 1111011, A = 1110111, b = 0011111
    - C = 1001110, d = 0111101, E = 1001111, F = 1000111
  - sseg[7] = shadow dp[k].
  - sseg is forced inactive whenever an is all inactive.
- Polarity: each output bit is inverted when the matching *_ACTIVE_LOW parameter is 1.
- Latency: an/sseg are registered, i.e. 1 cycle after the counter state that selects them.
  - An index change therefore shows as BLANK_CYC cycles of all-dark starting 1 cycle after the slot wrap.
- Counter widths: $clog2 of their ranges, minimum 1 bit. There is no overflow beyond the wrap points.

Decomposition:
- Shared package seg_pkg:
  - 16-entry SEG_LUT constant (abcdefg encoding above)
  - SEG_W = 8 and DIGIT_W = 4 constants
- One sub-module, seg_hex_decode: pure combinational 4-bit to 7-bit decoder using SEG_LUT.
  - Reused by other display blocks.

Test Plan (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2, active-high unless noted):
1. Reset then load hex_in=16'h3210, dp_in=4'b0100:
   - Per slot: 2 dark cycles, then 6 cycles of an=0001 with sseg=0_1111110.
   - Following slots: 0010 / 0_0110000, then 0100 / 1_1101101, then 1000 / 0_1111001.
   - frame_tick fires every 32 cycles.
2. Load hex_in=16'hFEDC on cycle 13 (mid-slot):
   - The digit shown from cycle 14 changes within the same slot to the new LUT value.
   - No glitch on an.
3. blank_in=4'b0010:
   - an never equals 0010.
   - sseg = 0 throughout slot 1 of every frame.
4. blink_in=4'b0001:
   - Digit 0 visible in frames 0–1, dark in frames 2–3, visible in frames 4–5.
   - Other digits are unaffected.
5. rst asserted at cycle 20 (mid-slot, digit 2), for 1 cycle:
   - Next cycle an=0000, sseg=00000000, frame_tick=0; shadows cleared.
   - Scan restarts at digit 0 with 2 blank cycles.
6. AN_ACTIVE_LOW=1, SEG_ACTIVE_LOW=1, hex 8 with dp=1 on digit 3:
   - During digit 3 visible window: an=0111, sseg=00000000.
   - During blank window: an=1111, sseg=11111111.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared seven-segment display constants: field widths and the hex-to-abcdefg
// glyph table used by every display block on the board.
package seg_pkg;

  localparam int SEG_W     = 8;
  localparam int DIGIT_W   = 4;
  localparam int ABCDEFG_W = 7;

  // Glyphs for 0..F, segment order abcdefg with bit 6 = a, active-high.
  // Entry 15 is listed first because this is a packed array.
  localparam logic [15:0][ABCDEFG_W-1:0] SEG_LUT = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  // Counter width for a modulo-'value' counter; never narrower than 1 bit.
  function automatic int clog2Min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Pure combinational hex-digit to abcdefg decoder, shared by display blocks.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [DIGIT_W-1:0]   i_hex,
  output logic [ABCDEFG_W-1:0] o_seg
);

  assign o_seg = SEG_LUT[i_hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: shadowed digit data, per-digit blanking
// and blinking, anti-ghosting dead time at the start of every digit slot and
// selectable pin polarity. Outputs are registered one cycle behind the scan
// counters that select them.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 100000,
  parameter int BLANK_CYC      = 1000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit AN_ACTIVE_LOW  = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] i_hex_in,
  input  logic [NUM_DIGITS-1:0]         i_dp_in,
  input  logic [NUM_DIGITS-1:0]         i_blank_in,
  input  logic [NUM_DIGITS-1:0]         i_blink_in,
  output logic [NUM_DIGITS-1:0]         o_an,
  output logic [SEG_W-1:0]              o_sseg,
  output logic                          o_frame_tick
);

  localparam int SLOT_W = clog2Min1(SCAN_DIV);
  localparam int IDX_W  = clog2Min1(NUM_DIGITS);
  localparam int FRM_W  = clog2Min1(BLINK_FRAMES);

  localparam logic [SLOT_W-1:0]     SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0]     SLOT_BLANK = SLOT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0]      FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [SEG_W-1:0]      SEG_OFF    = {SEG_W{SEG_ACTIVE_LOW}};

  logic [SLOT_W-1:0]             r_slotCnt;
  logic [IDX_W-1:0]              r_digitIdx;
  logic [FRM_W-1:0]              r_frameCnt;
  logic                          r_blinkPhase;
  logic [DIGIT_W*NUM_DIGITS-1:0] r_hexShadow;
  logic [NUM_DIGITS-1:0]         r_dpShadow;
  logic [NUM_DIGITS-1:0]         r_blankShadow;
  logic [NUM_DIGITS-1:0]         r_blinkShadow;
  logic [NUM_DIGITS-1:0]         r_an;
  logic [SEG_W-1:0]              r_sseg;
  logic                          r_frameTick;

  logic                          w_slotWrap;
  logic                          w_digitWrap;
  logic                          w_blinkWrap;
  logic [DIGIT_W-1:0]            w_curHex;
  logic [ABCDEFG_W-1:0]          w_curSegs;
  logic                          w_curDp;
  logic                          w_curBlank;
  logic                          w_curBlink;
  logic                          w_digitOn;
  logic [NUM_DIGITS-1:0]         w_anNext;
  logic [SEG_W-1:0]              w_ssegNext;

  assign w_slotWrap  = (r_slotCnt == SLOT_LAST);
  assign w_digitWrap = w_slotWrap && (r_digitIdx == IDX_LAST);
  assign w_blinkWrap = w_digitWrap && (r_frameCnt == FRM_LAST);

  seg_hex_decode u_decode (
    .i_hex (w_curHex),
    .o_seg (w_curSegs)
  );

  // Capture a coherent snapshot of the display data on the load strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hexShadow   <= '0;
      r_dpShadow    <= '0;
      r_blankShadow <= '0;
      r_blinkShadow <= '0;
    end else if (i_load) begin
      r_hexShadow   <= i_hex_in;
      r_dpShadow    <= i_dp_in;
      r_blankShadow <= i_blank_in;
      r_blinkShadow <= i_blink_in;
    end
  end

  // Scan timing chain: slot cycles -> digit index -> frame count -> blink phase.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_slotCnt    <= '0;
      r_digitIdx   <= '0;
      r_frameCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else begin
      r_slotCnt <= w_slotWrap ? '0 : r_slotCnt + 1'b1;
      if (w_slotWrap) begin
        r_digitIdx <= (r_digitIdx == IDX_LAST) ? '0 : r_digitIdx + 1'b1;
      end
      if (w_digitWrap) begin
        r_frameCnt <= (r_frameCnt == FRM_LAST) ? '0 : r_frameCnt + 1'b1;
      end
      if (w_blinkWrap) begin
        r_blinkPhase <= ~r_blinkPhase;
      end
    end
  end

  // Select the current digit's shadow data and decide whether it may light up.
  always_comb begin
    w_curHex   = r_hexShadow[r_digitIdx*DIGIT_W +: DIGIT_W];
    w_curDp    = r_dpShadow[r_digitIdx];
    w_curBlank = r_blankShadow[r_digitIdx];
    w_curBlink = r_blinkShadow[r_digitIdx];
    w_digitOn  = (r_slotCnt >= SLOT_BLANK) && !w_curBlank
                 && !(w_curBlink && r_blinkPhase);
    w_anNext   = AN_OFF;
    w_ssegNext = SEG_OFF;
    if (w_digitOn) begin
      w_anNext   = (NUM_DIGITS'(1) << r_digitIdx) ^ AN_OFF;
      w_ssegNext = {w_curDp, w_curSegs} ^ SEG_OFF;
    end
  end

  // Register the pin drive so the board sees glitch-free enables and segments.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_an        <= AN_OFF;
      r_sseg      <= SEG_OFF;
      r_frameTick <= 1'b0;
    end else begin
      r_an        <= w_anNext;
      r_sseg      <= w_ssegNext;
      r_frameTick <= w_digitWrap;
    end
  end

  assign o_an         = r_an;
  assign o_sseg       = r_sseg;
  assign o_frame_tick = r_frameTick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: a phase table drives the main
// instance while a closed-form scan model feeds a scoreboard queue, and a
// table of hand-computed spot vectors checks both an active-high and an
// active-low instance.
module tb_seg_scan_ctrl;

  localparam int NUM_DIGITS   = 4;
  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYC    = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int NUM_PHASES   = 13;
  localparam int NUM_SPOTS    = 15;

  typedef struct {
    logic [3:0] an;
    logic [7:0] sseg;
    logic       frameTick;
  } expT;

  typedef struct {
    logic        rst;
    logic        load;
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  blink;
    int          cycles;
  } phaseT;

  typedef struct {
    int         k;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       frameTick;
    logic [3:0] anL;
    logic [7:0] ssegL;
  } spotT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] hexIn = '0;
  logic [3:0]  dpIn = '0;
  logic [3:0]  blankIn = '0;
  logic [3:0]  blinkIn = '0;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frameTick;

  logic [15:0] hexL = 16'h8000;
  logic [3:0]  dpL = 4'b1000;
  logic [3:0]  zeroL = 4'b0000;
  logic [3:0]  anL;
  logic [7:0]  ssegL;
  logic        frameTickL;

  logic [6:0]  lutRef [16];
  phaseT       phases [NUM_PHASES];
  spotT        spots [NUM_SPOTS];
  expT         sbQ [$];

  int          passCount = 0;
  int          checkCount = 0;
  int          modelT = 0;
  int          kCnt = 0;
  logic [15:0] mHex = '0;
  logic [3:0]  mDp = '0;
  logic [3:0]  mBlank = '0;
  logic [3:0]  mBlink = '0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS     (NUM_DIGITS),
    .SCAN_DIV       (SCAN_DIV),
    .BLANK_CYC      (BLANK_CYC),
    .BLINK_FRAMES   (BLINK_FRAMES),
    .AN_ACTIVE_LOW  (1'b0),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_load       (load),
    .i_hex_in     (hexIn),
    .i_dp_in      (dpIn),
    .i_blank_in   (blankIn),
    .i_blink_in   (blinkIn),
    .o_an         (an),
    .o_sseg       (sseg),
    .o_frame_tick (frameTick)
  );

  seg_scan_ctrl #(
    .NUM_DIGITS     (NUM_DIGITS),
    .SCAN_DIV       (SCAN_DIV),
    .BLANK_CYC      (BLANK_CYC),
    .BLINK_FRAMES   (BLINK_FRAMES),
    .AN_ACTIVE_LOW  (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dutLow (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_load       (load),
    .i_hex_in     (hexL),
    .i_dp_in      (dpL),
    .i_blank_in   (zeroL),
    .i_blink_in   (zeroL),
    .o_an         (anL),
    .o_sseg       (ssegL),
    .o_frame_tick (frameTickL)
  );

  // Expected registered outputs after the next edge, given counter state t.
  function automatic expT modelExp(input int t, input logic r);
    expT  e;
    int   slot;
    int   dig;
    int   phase;
    logic on;
    e.an = '0;
    e.sseg = '0;
    e.frameTick = 1'b0;
    if (!r) begin
      slot  = t % SCAN_DIV;
      dig   = (t / SCAN_DIV) % NUM_DIGITS;
      phase = (t / (SCAN_DIV * NUM_DIGITS * BLINK_FRAMES)) % 2;
      on = (slot >= BLANK_CYC) && !mBlank[dig] && !(mBlink[dig] && phase == 1);
      if (on) begin
        e.an   = 4'b0001 << dig;
        e.sseg = {mDp[dig], lutRef[mHex[dig*4 +: 4]]};
      end
      e.frameTick = (slot == SCAN_DIV - 1) && (dig == NUM_DIGITS - 1);
    end
    return e;
  endfunction

  task automatic checkVal(input string what, input logic [7:0] act, input logic [7:0] req);
    checkCount++;
    if (act === req) passCount++;
    else $display("[TB] FAIL %s @%0t: got %h, expected %h", what, $time, act, req);
  endtask

  task automatic checkOutput();
    expT e;
    if (sbQ.size() == 0) begin
      checkCount++;
      $display("[TB] FAIL scoreboard @%0t: no expected entry queued", $time);
    end else begin
      e = sbQ.pop_front();
      checkVal("an", {4'b0, an}, {4'b0, e.an});
      checkVal("sseg", sseg, e.sseg);
      checkVal("frame_tick", {7'b0, frameTick}, {7'b0, e.frameTick});
    end
  endtask

  task automatic checkSpot();
    for (int i = 0; i < NUM_SPOTS; i++) begin
      if (spots[i].k == kCnt) begin
        checkVal($sformatf("spot%0d an", kCnt), {4'b0, an}, {4'b0, spots[i].an});
        checkVal($sformatf("spot%0d sseg", kCnt), sseg, spots[i].sseg);
        checkVal($sformatf("spot%0d frame_tick", kCnt), {7'b0, frameTick}, {7'b0, spots[i].frameTick});
        checkVal($sformatf("spot%0d anLow", kCnt), {4'b0, anL}, {4'b0, spots[i].anL});
        checkVal($sformatf("spot%0d ssegLow", kCnt), ssegL, spots[i].ssegL);
        checkVal($sformatf("spot%0d frame_tickLow", kCnt), {7'b0, frameTickL}, {7'b0, spots[i].frameTick});
      end
    end
  endtask

  // One clock: queue the expectation, drive inputs, advance the model, compare.
  task automatic applyStimulus(input logic r, input logic l, input logic [15:0] h,
                               input logic [3:0] d, input logic [3:0] b, input logic [3:0] k);
    sbQ.push_back(modelExp(modelT, r));
    rst = r;
    load = l;
    hexIn = h;
    dpIn = d;
    blankIn = b;
    blinkIn = k;
    @(posedge clk);
    if (r) begin
      modelT = 0;
      kCnt = 0;
      mHex = '0;
      mDp = '0;
      mBlank = '0;
      mBlink = '0;
    end else begin
      modelT++;
      kCnt++;
      if (l) begin
        mHex = h;
        mDp = d;
        mBlank = b;
        mBlink = k;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    load = 1'b0;
    checkOutput();
  endtask

  initial begin
    lutRef = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
               7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    phases[0]  = '{1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1};
    phases[1]  = '{1'b0, 1'b1, 16'h3210, 4'b0100, 4'b0000, 4'b0000, 64};
    phases[2]  = '{1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1};
    phases[3]  = '{1'b0, 1'b1, 16'h3210, 4'b0100, 4'b0000, 4'b0000, 13};
    phases[4]  = '{1'b0, 1'b1, 16'hFEDC, 4'b0000, 4'b0000, 4'b0000, 51};
    phases[5]  = '{1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1};
    phases[6]  = '{1'b0, 1'b1, 16'h3210, 4'b0100, 4'b0010, 4'b0000, 64};
    phases[7]  = '{1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1};
    phases[8]  = '{1'b0, 1'b1, 16'h3210, 4'b0000, 4'b0000, 4'b0001, 192};
    phases[9]  = '{1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1};
    phases[10] = '{1'b0, 1'b1, 16'h3210, 4'b0100, 4'b0000, 4'b0000, 20};
    phases[11] = '{1'b1, 1'b0, 16'h3210, 4'b0100, 4'b0000, 4'b0000, 1};
    phases[12] = '{1'b0, 1'b0, 16'h3210, 4'b0100, 4'b0000, 4'b0000, 40};

    spots[0]  = '{0,  4'b0000, 8'h00, 1'b0, 4'b1111, 8'hFF};
    spots[1]  = '{1,  4'b0000, 8'h00, 1'b0, 4'b1111, 8'hFF};
    spots[2]  = '{2,  4'b0000, 8'h00, 1'b0, 4'b1111, 8'hFF};
    spots[3]  = '{3,  4'b0001, 8'h7E, 1'b0, 4'b1110, 8'h81};
    spots[4]  = '{8,  4'b0001, 8'h7E, 1'b0, 4'b1110, 8'h81};
    spots[5]  = '{9,  4'b0000, 8'h00, 1'b0, 4'b1111, 8'hFF};
    spots[6]  = '{10, 4'b0000, 8'h00, 1'b0, 4'b1111, 8'hFF};
    spots[7]  = '{11, 4'b0010, 8'h30, 1'b0, 4'b1101, 8'h81};
    spots[8]  = '{19, 4'b0100, 8'hED, 1'b0, 4'b1011, 8'h81};
    spots[9]  = '{25, 4'b0000, 8'h00, 1'b0, 4'b1111, 8'hFF};
    spots[10] = '{27, 4'b1000, 8'h79, 1'b0, 4'b0111, 8'h00};
    spots[11] = '{32, 4'b1000, 8'h79, 1'b1, 4'b0111, 8'h00};
    spots[12] = '{33, 4'b0000, 8'h00, 1'b0, 4'b1111, 8'hFF};
    spots[13] = '{35, 4'b0001, 8'h7E, 1'b0, 4'b1110, 8'h81};
    spots[14] = '{64, 4'b1000, 8'h79, 1'b1, 4'b0111, 8'h00};

    @(negedge clk);

    for (int p = 0; p < NUM_PHASES; p++) begin
      applyStimulus(phases[p].rst, phases[p].load, phases[p].hex,
                    phases[p].dp, phases[p].blank, phases[p].blink);
      for (int c = 1; c < phases[p].cycles; c++) begin
        applyStimulus(1'b0, 1'b0, phases[p].hex, phases[p].dp,
                      phases[p].blank, phases[p].blink);
      end
    end

    applyStimulus(1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000);
    checkSpot();
    applyStimulus(1'b0, 1'b1, 16'h3210, 4'b0100, 4'b0000, 4'b0000);
    checkSpot();
    for (int k = 2; k <= 64; k++) begin
      applyStimulus(1'b0, 1'b0, 16'h3210, 4'b0100, 4'b0000, 4'b0000);
      checkSpot();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
